// File: rtl/risk_pkg.sv
// Shared types for the RISK issue sequencer: func codes, FSM states and the buffered op layout.
package risk_pkg;

  localparam logic [2:0] RISK_LOAD  = 3'b000;
  localparam logic [2:0] RISK_STORE = 3'b001;
  localparam logic [2:0] RISK_CLEAR = 3'b010;
  localparam logic [2:0] RISK_NOP   = 3'b111;

  localparam int RISK_OP_W = 51;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_STORE_RUN = 2'd2,
    ST_CLR       = 2'd3
  } risk_state_e;

  typedef struct packed {
    logic [2:0]  func;
    logic [4:0]  rg;
    logic [14:0] addr;
    logic [13:0] sx;
    logic [13:0] sy;
  } risk_op_t;

endpackage

// File: rtl/risk_issue_fifo.sv
// Synchronous op buffer for risk_issue. Full/empty come from the registered count only,
// so a write into a full buffer is refused even when a read happens in the same cycle.
module risk_issue_fifo
  import risk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         wr_en,
  input  logic [RISK_OP_W-1:0]         wr_data,
  input  logic                         rd_en,
  output logic [RISK_OP_W-1:0]         rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [RISK_OP_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/risk_issue.sv
// Sequencer feeding the RISK matrix unit: buffers core ops and plays each one out with the
// fixed timing of the strided memory pipeline, strictly one op at a time.
module risk_issue
  import risk_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LOAD_LAT   = 4,
  parameter int STORE_PRE  = 1,
  parameter int STORE_LAT  = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_func,
  input  logic [4:0]  in_reg,
  input  logic [14:0] in_addr,
  input  logic [13:0] in_stride_x,
  input  logic [13:0] in_stride_y,
  output logic [2:0]  risk_func,
  output logic [4:0]  risk_reg,
  output logic [14:0] risk_addr,
  output logic [13:0] risk_stride_x,
  output logic [13:0] risk_stride_y,
  output logic        busy,
  output logic        retire,
  output logic        err_illegal
);

  localparam int STORE_END = STORE_PRE + STORE_LAT;
  localparam int MAX_LAT   = (LOAD_LAT > STORE_END) ? LOAD_LAT : STORE_END;
  localparam int CNT_W     = $clog2(MAX_LAT) + 1;
  localparam int FCW       = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] LOAD_DONE  = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] STORE_HIT  = CNT_W'(STORE_PRE);
  localparam logic [CNT_W-1:0] STORE_DONE = CNT_W'(STORE_END);

  risk_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  risk_op_t             op_q, op_d;
  risk_op_t             in_op, head_op;
  logic [RISK_OP_W-1:0] head_bits;
  logic                 fifo_full, fifo_empty;
  logic [FCW-1:0]       fifo_count;
  logic                 pop, slot_free;

  assign in_op    = {in_func, in_reg, in_addr, in_stride_x, in_stride_y};
  assign head_op  = head_bits;
  assign in_ready = ~fifo_full;

  risk_issue_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (in_valid & in_ready),
    .wr_data (in_op),
    .rd_en   (pop),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    risk_func   = RISK_NOP;
    retire      = 1'b0;
    err_illegal = 1'b0;
    pop         = 1'b0;
    slot_free   = 1'b0;

    case (state_q)
      ST_IDLE: slot_free = 1'b1;
      ST_LOAD_WAIT: begin
        if (cnt_q == LOAD_DONE) begin
          risk_func = RISK_LOAD;
          retire    = 1'b1;
          slot_free = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STORE_RUN: begin
        if (cnt_q == STORE_HIT) risk_func = RISK_STORE;
        if (cnt_q == STORE_DONE) begin
          retire    = 1'b1;
          slot_free = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CLR: begin
        risk_func = RISK_CLEAR;
        retire    = 1'b1;
        slot_free = 1'b1;
      end
      default: slot_free = 1'b1;
    endcase

    // The retire cycle doubles as the next pop cycle, so ops stream with no extra bubble.
    if (slot_free) begin
      state_d = ST_IDLE;
      if (!fifo_empty) begin
        pop   = 1'b1;
        cnt_d = '0;
        case (head_op.func)
          RISK_LOAD: begin
            state_d = ST_LOAD_WAIT;
            op_d    = head_op;
          end
          RISK_STORE: begin
            state_d = ST_STORE_RUN;
            op_d    = head_op;
          end
          RISK_CLEAR: begin
            state_d = ST_CLR;
            op_d    = head_op;
          end
          default: err_illegal = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign risk_reg      = op_q.rg;
  assign risk_addr     = op_q.addr;
  assign risk_stride_x = op_q.sx;
  assign risk_stride_y = op_q.sy;
  assign busy          = (state_q != ST_IDLE) | (fifo_count != '0);

endmodule
